// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch flush
// and front-end freeze around the multi-cycle MDU, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
   parameter int CNT_W       = 32,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             uses_rs1_ID,
   input  logic             uses_rs2_ID,
   input  logic [4:0]       rd_EX,
   input  logic             mem_read_EX,
   input  logic             branch_taken_EX,
   input  logic             mdu_op_EX,
   input  logic             mdu_done,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_bubble,
   output logic             mdu_start,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mdu_timeout
);

   localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
   localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  STALL_ONE = CNT_W'(32'd1);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MDU_WAIT   = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic [WAIT_W-1:0]   wait_cnt_nxt_s;
   logic [CNT_W-1:0]    stall_cycles_r;
   logic                mdu_timeout_r;
   logic                timeout_set_s;
   logic                load_use_s;
   logic                pc_write_s;
   logic                if_id_write_s;
   logic                id_ex_write_s;
   logic                if_id_flush_s;
   logic                id_ex_bubble_s;
   logic                ex_mem_bubble_s;
   logic                mdu_start_s;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use_s = mem_read_EX && (rd_EX != 5'd0) &&
                       ((uses_rs1_ID && (rs1_ID == rd_EX)) ||
                        (uses_rs2_ID && (rs2_ID == rd_EX)));

   // Pipeline control decode and next-state selection
   always_comb begin
      pc_write_s      = 1'b1;
      if_id_write_s   = 1'b1;
      id_ex_write_s   = 1'b1;
      if_id_flush_s   = 1'b0;
      id_ex_bubble_s  = 1'b0;
      ex_mem_bubble_s = 1'b0;
      mdu_start_s     = 1'b0;
      timeout_set_s   = 1'b0;
      state_nxt_s     = ST_RUN;
      wait_cnt_nxt_s  = wait_cnt_r;
      if (rst) begin
         pc_write_s      = 1'b0;
         if_id_write_s   = 1'b0;
         id_ex_write_s   = 1'b0;
         if_id_flush_s   = 1'b1;
         id_ex_bubble_s  = 1'b1;
         ex_mem_bubble_s = 1'b1;
         wait_cnt_nxt_s  = {WAIT_W{1'b0}};
      end else begin
         case (state_r)
            ST_RUN, ST_LOAD_STALL: begin
               if (mdu_op_EX) begin
                  mdu_start_s     = 1'b1;
                  pc_write_s      = 1'b0;
                  if_id_write_s   = 1'b0;
                  id_ex_write_s   = 1'b0;
                  ex_mem_bubble_s = 1'b1;
                  wait_cnt_nxt_s  = {WAIT_W{1'b0}};
                  state_nxt_s     = ST_MDU_WAIT;
               end else if (branch_taken_EX) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
                  state_nxt_s    = ST_RUN;
               end else if (load_use_s && (state_r == ST_RUN)) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_bubble_s = 1'b1;
                  state_nxt_s    = ST_LOAD_STALL;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_MDU_WAIT: begin
               // A done on the watchdog cycle wins, so the timeout flag is not raised
               if (mdu_done) begin
                  state_nxt_s = ST_RUN;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  timeout_set_s = 1'b1;
                  state_nxt_s   = ST_RUN;
               end else begin
                  pc_write_s      = 1'b0;
                  if_id_write_s   = 1'b0;
                  id_ex_write_s   = 1'b0;
                  ex_mem_bubble_s = 1'b1;
                  wait_cnt_nxt_s  = wait_cnt_r + WAIT_ONE;
                  state_nxt_s     = ST_MDU_WAIT;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // State, watchdog, sticky timeout flag and saturating stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_RUN;
         wait_cnt_r     <= {WAIT_W{1'b0}};
         stall_cycles_r <= {CNT_W{1'b0}};
         mdu_timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         if (timeout_set_s) begin
            mdu_timeout_r <= 1'b1;
         end else begin
            mdu_timeout_r <= mdu_timeout_r;
         end
         if (!pc_write_s && (stall_cycles_r != STALL_MAX)) begin
            stall_cycles_r <= stall_cycles_r + STALL_ONE;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign pc_write      = pc_write_s;
   assign if_id_write   = if_id_write_s;
   assign id_ex_write   = id_ex_write_s;
   assign if_id_flush   = if_id_flush_s;
   assign id_ex_bubble  = id_ex_bubble_s;
   assign ex_mem_bubble = ex_mem_bubble_s;
   assign mdu_start     = mdu_start_s;
   assign stall_cycles  = stall_cycles_r;
   assign mdu_timeout   = mdu_timeout_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (CNT_W=3, MDU_TIMEOUT=8).
module tb_hazard_stall_controller;

   localparam int CNT_W = 3;

   // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble, mdu_start}
   localparam logic [6:0] C_NORMAL = 7'b111_000_0;
   localparam logic [6:0] C_LU     = 7'b001_010_0;
   localparam logic [6:0] C_BR     = 7'b111_110_0;
   localparam logic [6:0] C_START  = 7'b000_001_1;
   localparam logic [6:0] C_FROZEN = 7'b000_001_0;
   localparam logic [6:0] C_RST    = 7'b000_111_0;

   logic             clk;
   logic             rst;
   logic [4:0]       rs1_ID;
   logic [4:0]       rs2_ID;
   logic             uses_rs1_ID;
   logic             uses_rs2_ID;
   logic [4:0]       rd_EX;
   logic             mem_read_EX;
   logic             branch_taken_EX;
   logic             mdu_op_EX;
   logic             mdu_done;
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             ex_mem_bubble;
   logic             mdu_start;
   logic [CNT_W-1:0] stall_cycles;
   logic             mdu_timeout;
   logic [6:0]       ctrl;

   int checks = 0;
   int passes = 0;

   hazard_stall_controller #(.CNT_W(CNT_W), .MDU_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
      .rd_EX(rd_EX), .mem_read_EX(mem_read_EX),
      .branch_taken_EX(branch_taken_EX), .mdu_op_EX(mdu_op_EX), .mdu_done(mdu_done),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
      .mdu_start(mdu_start), .stall_cycles(stall_cycles), .mdu_timeout(mdu_timeout)
   );

   assign ctrl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble, mdu_start};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Test time sits 1 unit after a rising edge; outputs are sampled mid-cycle.
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      rs1_ID = 5'd0; rs2_ID = 5'd0; uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0;
      rd_EX = 5'd0; mem_read_EX = 1'b0; branch_taken_EX = 1'b0;
      mdu_op_EX = 1'b0; mdu_done = 1'b0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2);
      mem_read_EX = 1'b1; rd_EX = rd;
      rs1_ID = r1; uses_rs1_ID = u1; rs2_ID = r2; uses_rs2_ID = u2;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1'b1;
      #4;
      checks++; if (ctrl !== C_RST) $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST); else passes++;
      next_cycle();
      checks++; if (stall_cycles !== 3'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cycles); else passes++;
      checks++; if (mdu_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", mdu_timeout); else passes++;
      rst = 1'b0;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL reset_release: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
   endtask

   task automatic test_load_use;
      do_reset();
      set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
      #4;
      checks++; if (ctrl !== C_LU) $display("FAIL lu_rs1: got %b expected %b", ctrl, C_LU); else passes++;
      next_cycle();
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL lu_masked: got %b expected %b", ctrl, C_NORMAL); else passes++;
      checks++; if (stall_cycles !== 3'd1) $display("FAIL lu_count: got %0d expected 1", stall_cycles); else passes++;
      next_cycle();
      set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
      #4;
      checks++; if (ctrl !== C_LU) $display("FAIL lu_rs2: got %b expected %b", ctrl, C_LU); else passes++;
      next_cycle();
      clear_inputs();
      #4;
      checks++; if (stall_cycles !== 3'd2) $display("FAIL lu_count2: got %0d expected 2", stall_cycles); else passes++;
      next_cycle();
   endtask

   task automatic test_no_stall;
      do_reset();
      set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL nostall_x0: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      set_load_use(5'd5, 5'd5, 1'b0, 5'd1, 1'b1);
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL nostall_unused: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      set_load_use(5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
      mem_read_EX = 1'b0;
      mdu_done = 1'b1;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL nostall_noload: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      clear_inputs();
      checks++; if (stall_cycles !== 3'd0) $display("FAIL nostall_count: got %0d expected 0", stall_cycles); else passes++;
   endtask

   task automatic test_branch_priority;
      do_reset();
      set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
      branch_taken_EX = 1'b1;
      #4;
      checks++; if (ctrl !== C_BR) $display("FAIL br_flush: got %b expected %b", ctrl, C_BR); else passes++;
      next_cycle();
      // Still in RUN (not LOAD_STALL): a lingering hazard must stall again
      branch_taken_EX = 1'b0;
      #4;
      checks++; if (ctrl !== C_LU) $display("FAIL br_no_loadstall: got %b expected %b", ctrl, C_LU); else passes++;
      checks++; if (stall_cycles !== 3'd0) $display("FAIL br_count: got %0d expected 0", stall_cycles); else passes++;
      next_cycle();
      clear_inputs();
      set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
      branch_taken_EX = 1'b1;
      mdu_op_EX = 1'b1;
      #4;
      checks++; if (ctrl !== C_START) $display("FAIL mdu_over_branch: got %b expected %b", ctrl, C_START); else passes++;
      next_cycle();
      clear_inputs();
      mdu_done = 1'b1;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL mdu_over_branch_rel: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_mdu_done;
      int bad;
      do_reset();
      mdu_op_EX = 1'b1;
      #4;
      checks++; if (ctrl !== C_START) $display("FAIL mdu_start: got %b expected %b", ctrl, C_START); else passes++;
      next_cycle();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         #4;
         if (ctrl !== C_FROZEN) begin
            bad++;
            $display("FAIL mdu_frozen[%0d]: got %b expected %b", i, ctrl, C_FROZEN);
         end
         next_cycle();
      end
      checks++; if (bad == 0) passes++;
      mdu_done = 1'b1;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL mdu_release: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      clear_inputs();
      #4;
      checks++; if (stall_cycles !== 3'd5) $display("FAIL mdu_count: got %0d expected 5", stall_cycles); else passes++;
      checks++; if (mdu_timeout !== 1'b0) $display("FAIL mdu_no_timeout: got %b expected 0", mdu_timeout); else passes++;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL mdu_after: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
   endtask

   task automatic test_mdu_timeout(input logic done_on_last);
      int bad;
      do_reset();
      mdu_op_EX = 1'b1;
      #4;
      bad = 0;
      if (ctrl !== C_START) begin bad++; $display("FAIL to_start: got %b expected %b", ctrl, C_START); end
      next_cycle();
      for (int i = 1; i < 8; i++) begin
         #4;
         if (ctrl !== C_FROZEN) begin
            bad++;
            $display("FAIL to_frozen[%0d]: got %b expected %b", i, ctrl, C_FROZEN);
         end
         next_cycle();
      end
      checks++; if (bad == 0) passes++;
      mdu_done = done_on_last;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL to_release: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
      clear_inputs();
      // 8 frozen cycles against a 3-bit counter: must saturate at 7, not wrap
      checks++; if (stall_cycles !== 3'd7) $display("FAIL to_saturate: got %0d expected 7", stall_cycles); else passes++;
      checks++; if (mdu_timeout !== !done_on_last) $display("FAIL to_flag: got %b expected %b", mdu_timeout, !done_on_last); else passes++;
      next_cycle();
      set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      next_cycle();
      clear_inputs();
      next_cycle();
      checks++; if (stall_cycles !== 3'd7) $display("FAIL to_sat_hold: got %0d expected 7", stall_cycles); else passes++;
      checks++; if (mdu_timeout !== !done_on_last) $display("FAIL to_sticky: got %b expected %b", mdu_timeout, !done_on_last); else passes++;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      checks++; if (mdu_timeout !== 1'b0) $display("FAIL to_rst_clear: got %b expected 0", mdu_timeout); else passes++;
   endtask

   task automatic test_reset_mid_mdu;
      do_reset();
      mdu_op_EX = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      #4;
      checks++; if (ctrl !== C_RST) $display("FAIL midrst_ctrl: got %b expected %b", ctrl, C_RST); else passes++;
      next_cycle();
      rst = 1'b0;
      mdu_op_EX = 1'b0;
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL midrst_run: got %b expected %b", ctrl, C_NORMAL); else passes++;
      checks++; if (stall_cycles !== 3'd0) $display("FAIL midrst_count: got %0d expected 0", stall_cycles); else passes++;
      next_cycle();
      #4;
      checks++; if (ctrl !== C_NORMAL) $display("FAIL midrst_nostart: got %b expected %b", ctrl, C_NORMAL); else passes++;
      next_cycle();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_priority();
      test_mdu_done();
      test_mdu_timeout(1'b0);
      test_mdu_timeout(1'b1);
      test_reset_mid_mdu();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
